// File: rtl/mod_reg4_4to1.sv
// mod_reg4_4to1: parallel-to-serial byte register, loads N bytes and emits byte 0 first
module mod_reg4_4to1 #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [N-1:0][7:0] i,
    input  logic              rd_en,
    output logic [7:0]        o,
    output logic              o_valid,
    output logic              o_last,
    output logic              reg_empty,
    output logic              wr_drop
);
    localparam int CW = $clog2(N);
    logic [N-1:0][7:0] buf_q;
    logic [CW-1:0]     cnt;
    // load when empty, otherwise serve reads and flag any load attempt as dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q     <= '0;
            cnt       <= '0;
            o         <= 8'h00;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            wr_drop   <= 1'b0;
            reg_empty <= 1'b1;
        end else begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            wr_drop <= 1'b0;
            if (reg_empty) begin
                if (wr_en) begin
                    buf_q     <= i;
                    cnt       <= '0;
                    reg_empty <= 1'b0;
                end
            end else begin
                wr_drop <= wr_en;
                if (rd_en) begin
                    o       <= buf_q[cnt];
                    o_valid <= 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        o_last    <= 1'b1;
                        cnt       <= '0;
                        reg_empty <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/mod_reg4_4to1.md
Name: mod_reg4_4to1

Overview:
- Parallel-to-serial byte register. It is the counterpart of the 1-to-4 collector register.
- Loads one N-byte word in a single cycle, then emits it one byte per read request, byte index 0 first.
- Used on the AES core output path to turn word/state results back into a byte stream for the byte-wide host interface.

Parameters:
- N, 4, number of bytes per parallel word (≥2). Internal counter width is clog2(N).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  load request for the parallel word on i.
- i  input  N x 8  parallel word; i[0] is emitted first.
- rd_en  input  1  request to emit the next byte.
- o  output  8  serial byte output; holds its value between reads.
- o_valid  output  1  one-cycle pulse: o was updated this cycle.
- o_last  output  1  one-cycle pulse, coincident with o_valid, when o carries byte N-1.
- reg_empty  output  1  1 means no undelivered bytes are held and a load is accepted.
- wr_drop  output  1  one-cycle pulse: a wr_en was ignored because the register was not empty.

Behaviour:
- Reset, when reset=1 at a clock edge:
  - counter=0 and all buffer bytes=8'h00.
  - o=8'h00, o_valid=0, o_last=0, wr_drop=0.
  - reg_empty=1, so the block is immediately ready to load.
  - Reset overrides wr_en and rd_en in the same cycle. Reset mid-stream discards all remaining bytes.
- Load (wr_en=1 and reg_empty=1):
  - buffer[k] <= i[k] for every k; counter <= 0; reg_empty <= 0.
  - o is unchanged and o_valid=0; no byte is emitted on the load cycle.
- Dropped load (wr_en=1 and reg_empty=0):
  - Buffer, counter and reg_empty are unchanged.
  - wr_drop=1 on the next cycle.
- Read (rd_en=1 and reg_empty=0):
  - o <= buffer[counter]; o_valid <= 1.
  - If counter==N-1: o_last <= 1, counter <= 0, reg_empty <= 1.
  - Otherwise counter <= counter+1.
  - Read latency is 1 cycle: o and o_valid are visible in the cycle after the edge that sampled rd_en.
- Read while empty (rd_en=1 and reg_empty=1, wr_en=0): no state change, o holds, o_valid=0.
- Simultaneous wr_en and rd_en:
  - If reg_empty=1: the load is performed and rd_en is ignored. The first byte needs a later read.
  - If reg_empty=0: the read is performed and the load is dropped (wr_drop=1). This applies even on the cycle that reads byte N-1.
  - A new load is accepted from the cycle after reg_empty returns to 1.
- Back-to-back reads: rd_en held at 1 emits N bytes on N consecutive cycles, then o_valid stays 0.
- Throughput:
  - Best sustained rate is N bytes per N+1 cycles (one load cycle plus N read cycles).
  - No bubble is allowed between reads.
- Pulse outputs: o_valid, o_last and wr_drop are registered and default to 0 every cycle unless set as above.
- State is implied by reg_empty:
  - EMPTY (reg_empty=1): accepts a load.
  - HOLDING (reg_empty=0): counter indexes the next byte.
  - EMPTY→HOLDING on a load; HOLDING→EMPTY on the read of byte N-1. No other transitions except reset.
- Counter wrap: the counter never exceeds N-1; its wrap to 0 coincides with reg_empty rising.

Test Plan:
- Reset, then idle → o=00, o_valid=0, o_last=0, wr_drop=0, reg_empty=1. Assert reset mid-stream after 2 reads → same values next cycle; the remaining bytes are never emitted.
- Load i={i[3]=DD,i[2]=CC,i[1]=BB,i[0]=AA}, then rd_en=1 for 4 cycles → o=AA,BB,CC,DD on consecutive cycles with o_valid=1 each. o_last=1 only with DD; reg_empty=1 after DD.
- During HOLDING, pulse wr_en with i={44,33,22,11} → wr_drop=1 next cycle. The subsequent reads still return AA,BB,CC,DD.
- Issue wr_en and rd_en together while empty with i={04,03,02,01} → load only, o_valid=0. Four more reads return 01,02,03,04.
- On the read of the last byte (DD), also assert wr_en with a new word → DD is emitted, the load is dropped (wr_drop=1) and reg_empty=1. A load on the next cycle succeeds.
- With reg_empty=1, assert rd_en for 3 cycles → o holds its last value, o_valid=0, counter unchanged. Repeat one load/read sequence with N=16 and i[k]=k → 00..0F in order, o_last only with 0F.
